sha_mem_loader: RTL and testbench

Host-side loader that sits directly upstream of RISC_Top. It receives a byte stream of framed records and turns it into the DMAD/DMAI memory-write cycles that preload data and instruction memory. It then drives start_in and holds it until the core reports state_done, and returns to idle for the next job. This block replaces hand-driven memory preload and start sequencing.

---
 rtl/sha_loader_pkg.sv | 18 +
 rtl/sha_loader_be_assembler.sv | 33 +++
 rtl/sha_mem_loader.sv | 155 +++++++++++++++
 tb/tb_sha_mem_loader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha_loader_pkg.sv
// Shared constants and FSM state encoding for the RISC_Top memory preload loader.
package sha_loader_pkg;

    localparam logic [7:0] CMD_WR_DMEM = 8'h01;
    localparam logic [7:0] CMD_WR_IMEM = 8'h02;
    localparam logic [7:0] CMD_START   = 8'h03;

    localparam logic [7:0] WE_ALL = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_WRITE,
        S_RUN
    } state_t;

endpackage

// File: rtl/sha_loader_be_assembler.sv
// Four-byte MSB-first word assembler shared by the address and data phases of a frame.
module sha_loader_be_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        load,
    input  logic [7:0]  data,
    output logic [31:0] word_next,
    output logic        done
);

    logic [23:0] shift_q;
    logic [1:0]  cnt_q;

    // word_next already includes the byte being loaded, so the caller can
    // capture a complete word on the same edge that accepts its last byte.
    assign word_next = {shift_q, data};
    assign done      = load && !clear && (cnt_q == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (clear) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (load) begin
            shift_q <= word_next[23:0];
            cnt_q   <= cnt_q + 2'd1;
        end
    end

endmodule

// File: rtl/sha_mem_loader.sv
// Byte-stream loader: turns framed records into DMAD/DMAI write cycles, then starts RISC_Top.
module sha_mem_loader
    import sha_loader_pkg::*;
#(
    parameter int WE_HOLD   = 1,
    parameter int REC_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_valid,
    input  logic [7:0]           s_data,
    output logic                 s_ready,
    output logic [31:0]          dmad_addr_o,
    output logic [31:0]          dmad_data_o,
    output logic [7:0]           dmad_we_o,
    output logic [31:0]          dmai_addr_o,
    output logic [31:0]          dmai_data_o,
    output logic [7:0]           dmai_we_o,
    output logic                 start_o,
    input  logic                 state_done_i,
    output logic                 busy_o,
    output logic                 err_o,
    output logic [REC_CNT_W-1:0] rec_count_o
);

    localparam logic [3:0] HOLD_INIT = 4'(WE_HOLD - 1);

    state_t      state, state_next;
    logic        xfer;
    logic        asm_clear, asm_load, asm_done;
    logic [31:0] asm_word;
    logic        tgt_imem;
    logic [31:0] addr_q;
    logic [3:0]  hold_cnt;

    assign xfer   = s_valid && s_ready;
    assign busy_o = (state != S_IDLE);

    sha_loader_be_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (asm_clear),
        .load      (asm_load),
        .data      (s_data),
        .word_next (asm_word),
        .done      (asm_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        asm_clear  = 1'b0;
        asm_load   = 1'b0;
        case (state)
            S_IDLE: begin
                s_ready = 1'b1;
                if (xfer) begin
                    if (s_data == CMD_WR_DMEM || s_data == CMD_WR_IMEM) begin
                        asm_clear  = 1'b1;
                        state_next = S_ADDR;
                    end else if (s_data == CMD_START) begin
                        state_next = S_RUN;
                    end
                end
            end
            S_ADDR: begin
                s_ready  = 1'b1;
                asm_load = xfer;
                if (asm_done) state_next = S_DATA;
            end
            S_DATA: begin
                s_ready  = 1'b1;
                asm_load = xfer;
                if (asm_done) state_next = S_WRITE;
            end
            S_WRITE: begin
                if (hold_cnt == 4'd0) state_next = S_IDLE;
            end
            S_RUN: begin
                if (state_done_i) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tgt_imem    <= 1'b0;
            addr_q      <= '0;
            hold_cnt    <= '0;
            dmad_addr_o <= '0;
            dmad_data_o <= '0;
            dmad_we_o   <= '0;
            dmai_addr_o <= '0;
            dmai_data_o <= '0;
            dmai_we_o   <= '0;
            start_o     <= 1'b0;
            err_o       <= 1'b0;
            rec_count_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (xfer) begin
                        if (s_data == CMD_WR_DMEM || s_data == CMD_WR_IMEM) begin
                            tgt_imem <= (s_data == CMD_WR_IMEM);
                        end else if (s_data == CMD_START) begin
                            start_o     <= 1'b1;
                            err_o       <= 1'b0;
                            rec_count_o <= '0;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                end
                S_ADDR: begin
                    if (asm_done) addr_q <= asm_word;
                end
                S_DATA: begin
                    // Address, data and enable of the target port all change on this edge.
                    if (asm_done) begin
                        hold_cnt <= HOLD_INIT;
                        if (tgt_imem) begin
                            dmai_addr_o <= addr_q;
                            dmai_data_o <= asm_word;
                            dmai_we_o   <= WE_ALL;
                        end else begin
                            dmad_addr_o <= addr_q;
                            dmad_data_o <= asm_word;
                            dmad_we_o   <= WE_ALL;
                        end
                    end
                end
                S_WRITE: begin
                    if (hold_cnt == 4'd0) begin
                        dmad_we_o <= '0;
                        dmai_we_o <= '0;
                        if (rec_count_o != '1) rec_count_o <= rec_count_o + 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end
                S_RUN: begin
                    if (state_done_i) start_o <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha_mem_loader.sv
// Scoreboard bench for sha_mem_loader: one instance with WE_HOLD=1, one with WE_HOLD=3.
module tb_sha_mem_loader;

    typedef struct {
        logic        imem;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk, reset, state_done, sel3;
    logic        drv_valid;
    logic [7:0]  drv_data;
    logic        v1, v3;

    logic        rdy1, start1, busy1, err1;
    logic [31:0] dmad_addr1, dmad_data1, dmai_addr1, dmai_data1;
    logic [7:0]  dmad_we1, dmai_we1;
    logic [15:0] rec1;

    logic        rdy3, start3, busy3, err3;
    logic [31:0] dmad_addr3, dmad_data3, dmai_addr3, dmai_data3;
    logic [7:0]  dmad_we3, dmai_we3;
    logic [15:0] rec3;

    wr_t q1[$];
    wr_t q3[$];
    wr_t e1, e3;
    int  len1, len3;
    int  n_checks, n_errors;

    assign v1 = sel3 ? 1'b0 : drv_valid;
    assign v3 = sel3 ? drv_valid : 1'b0;

    sha_mem_loader #(.WE_HOLD(1), .REC_CNT_W(16)) dut (
        .clk(clk), .reset(reset), .s_valid(v1), .s_data(drv_data), .s_ready(rdy1),
        .dmad_addr_o(dmad_addr1), .dmad_data_o(dmad_data1), .dmad_we_o(dmad_we1),
        .dmai_addr_o(dmai_addr1), .dmai_data_o(dmai_data1), .dmai_we_o(dmai_we1),
        .start_o(start1), .state_done_i(state_done), .busy_o(busy1), .err_o(err1),
        .rec_count_o(rec1)
    );

    sha_mem_loader #(.WE_HOLD(3), .REC_CNT_W(16)) dut3 (
        .clk(clk), .reset(reset), .s_valid(v3), .s_data(drv_data), .s_ready(rdy3),
        .dmad_addr_o(dmad_addr3), .dmad_data_o(dmad_data3), .dmad_we_o(dmad_we3),
        .dmai_addr_o(dmai_addr3), .dmai_data_o(dmai_data3), .dmai_we_o(dmai_we3),
        .start_o(start3), .state_done_i(state_done), .busy_o(busy3), .err_o(err3),
        .rec_count_o(rec3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            len1 = 0;
        end else if (dmad_we1 != 8'h00 || dmai_we1 != 8'h00) begin
            if (len1 == 0) begin
                if (q1.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    e1 = q1.pop_front();
                    chk("wr_port", {63'd0, dmai_we1 != 8'h00}, {63'd0, e1.imem});
                    chk("wr_addr", e1.imem ? dmai_addr1 : dmad_addr1, e1.addr);
                    chk("wr_data", e1.imem ? dmai_data1 : dmad_data1, e1.data);
                end
            end
            chk("we_exclusive", {63'd0, dmad_we1 != 8'h00 && dmai_we1 != 8'h00}, 0);
            chk("we_value", dmad_we1 | dmai_we1, 8'hFF);
            chk("s_ready_in_write", rdy1, 0);
            chk("start_in_write", start1, 0);
            len1++;
        end else if (len1 != 0) begin
            chk("we_len", len1, 1);
            len1 = 0;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            len3 = 0;
        end else if (dmad_we3 != 8'h00 || dmai_we3 != 8'h00) begin
            if (len3 == 0) begin
                if (q3.size() == 0) begin
                    chk("unexpected_write3", 1, 0);
                end else begin
                    e3 = q3.pop_front();
                    chk("wr3_port", {63'd0, dmai_we3 != 8'h00}, {63'd0, e3.imem});
                    chk("wr3_addr", e3.imem ? dmai_addr3 : dmad_addr3, e3.addr);
                    chk("wr3_data", e3.imem ? dmai_data3 : dmad_data3, e3.data);
                end
            end
            chk("we3_value", dmad_we3 | dmai_we3, 8'hFF);
            chk("s_ready3_in_write", rdy3, 0);
            len3++;
        end else if (len3 != 0) begin
            chk("we3_len", len3, 3);
            len3 = 0;
        end
    end

    task automatic idle(input int n);
        drv_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds s_valid with the byte until an edge where s_ready was high.
    task automatic send_byte(input logic [7:0] b);
        logic rdy;
        logic acc;
        acc       = 1'b0;
        drv_valid = 1'b1;
        drv_data  = b;
        for (int i = 0; i < 100; i++) begin
            rdy = sel3 ? rdy3 : rdy1;
            @(posedge clk);
            #1;
            if (rdy) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr,
                              input logic [31:0] data, input bit gap);
        logic [71:0] bytes;
        wr_t w;
        w.imem = (cmd == 8'h02);
        w.addr = addr;
        w.data = data;
        if (sel3) q3.push_back(w);
        else      q1.push_back(w);
        bytes = {cmd, addr, data};
        for (int i = 8; i >= 0; i--) begin
            send_byte(bytes[i*8 +: 8]);
            if (i == 0) begin
                drv_valid = 1'b0;
                if (sel3) chk("we_after_last3", {63'd0, (dmad_we3 | dmai_we3) == 8'hFF}, 1);
                else      chk("we_after_last", {63'd0, (dmad_we1 | dmai_we1) == 8'hFF}, 1);
            end else if (gap) begin
                idle(1);
            end
        end
        drv_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic ok;
        n_checks   = 0;
        n_errors   = 0;
        len1       = 0;
        len3       = 0;
        reset      = 1'b1;
        state_done = 1'b0;
        sel3       = 1'b0;
        drv_valid  = 1'b0;
        drv_data   = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", rdy1, 1);
        chk("rst_outputs", {dmad_we1, dmai_we1, start1, busy1, err1, rec1}, 0);
        chk("rst_addr_data", {dmad_addr1, dmai_data1}, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // DMEM write, valid held
        send_frame(8'h01, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        idle(3);
        chk("rec_after_w1", rec1, 1);
        chk("busy_after_w1", busy1, 0);

        // IMEM write with s_valid gaps
        send_frame(8'h02, 32'h0000_0004, 32'h0050_0093, 1'b1);
        idle(3);
        chk("rec_after_w2", rec1, 2);
        chk("dmad_kept", dmad_data1, 32'hDEAD_BEEF);

        // START held until state_done
        send_byte(8'h03);
        drv_valid = 1'b0;
        chk("start_rise", start1, 1);
        chk("rec_clear_on_run", rec1, 0);
        chk("busy_in_run", busy1, 1);
        chk("s_ready_in_run", rdy1, 0);
        ok = 1'b1;
        repeat (50) begin
            @(posedge clk);
            #1;
            ok = ok & start1;
        end
        chk("start_held", ok, 1);
        state_done = 1'b1;
        @(posedge clk);
        #1;
        chk("start_drop", start1, 0);
        chk("busy_after_run", busy1, 0);
        state_done = 1'b0;

        // Bad command, then a good write, then START with state_done already high
        send_byte(8'h7E);
        drv_valid = 1'b0;
        chk("err_set", err1, 1);
        chk("busy_after_bad", busy1, 0);
        send_frame(8'h02, 32'h0000_0040, 32'hCAFE_F00D, 1'b0);
        idle(2);
        chk("err_sticky", err1, 1);
        chk("rec_after_w3", rec1, 1);
        state_done = 1'b1;
        send_byte(8'h03);
        drv_valid = 1'b0;
        chk("start_pulse_hi", start1, 1);
        chk("err_cleared", err1, 0);
        @(posedge clk);
        #1;
        chk("start_pulse_lo", start1, 0);
        chk("busy_after_pulse", busy1, 0);
        state_done = 1'b0;

        // Reset mid-frame after the third address byte
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        drv_valid = 1'b0;
        chk("busy_mid_frame", busy1, 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_addr", {dmad_addr1, dmai_addr1}, 0);
        chk("rst_mid_data", {dmad_data1, dmai_data1}, 0);
        chk("rst_mid_ctrl", {dmad_we1, dmai_we1, start1, busy1, err1, rec1}, 0);
        chk("rst_mid_s_ready", rdy1, 1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        send_frame(8'h01, 32'h0000_0020, 32'h0000_0001, 1'b0);
        idle(3);
        chk("rec_after_rst_write", rec1, 1);

        // WE_HOLD=3 instance
        sel3 = 1'b1;
        send_frame(8'h01, 32'h0000_0080, 32'hA5A5_A5A5, 1'b0);
        idle(6);
        chk("rec3_after_write", rec3, 1);
        chk("busy3_after_write", busy3, 0);
        chk("q3_drained", q3.size(), 0);
        sel3 = 1'b0;

        chk("q1_drained", q1.size(), 0);
        chk("dut3_quiet", {start3, err3, dmai_we3, dmai_addr3, dmai_data3}, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
